// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: state encoding, halt encoding and counter helper.
package fetch_unit_pkg;

  // Fetch FSM encoding; decode relies on these values, so keep them fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Instruction encoding that ends execution (shared with decode).
  localparam logic [8:0] HALT_INS_DEF = 9'h1FF;

  // Width of the delivered-instruction counter.
  localparam int CNT_W = 16;

  // Saturating increment for the delivered-instruction counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Per-core instruction fetch stage. Owns the PC, drives ins_mem and pairs
// the 1-cycle-latency instruction with its PC and a valid flag for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    INS_WIDTH  = 9,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [INS_WIDTH-1:0]  HALT_INS   = INS_WIDTH'(HALT_INS_DEF)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic [INS_WIDTH-1:0]  ins_in,
  output logic [ADDR_WIDTH-1:0] PC_address,
  output logic                  rEn,
  output logic [INS_WIDTH-1:0]  ins_out,
  output logic [ADDR_WIDTH-1:0] ins_pc,
  output logic                  ins_valid,
  output logic                  done,
  output logic [CNT_W-1:0]      fetch_count
);

  fetch_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_pend_valid;
  logic [ADDR_WIDTH-1:0] r_pend_pc;
  logic                  r_done;
  logic [CNT_W-1:0]      r_count;

  logic                  w_run;
  logic                  w_halt;
  logic                  w_jump;
  logic [ADDR_WIDTH-1:0] w_pc_inc;

  // Advancing cycle: fetching and decode is not pushing back.
  assign w_run    = (r_state == ST_FETCH) && !stall;
  // Halt wins over a simultaneous jump on the same presented instruction.
  assign w_halt   = w_run && r_pend_valid && (ins_in == HALT_INS);
  assign w_jump   = w_run && r_pend_valid && jump && !w_halt;
  // Natural wrap from the top address back to zero.
  assign w_pc_inc = r_pc + ADDR_WIDTH'(1);

  // Output decode; ins_mem holds its output whenever rEn is low.
  assign rEn         = w_run;
  assign PC_address  = r_pc;
  assign ins_out     = ins_in;
  assign ins_pc      = r_pend_pc;
  assign ins_valid   = r_pend_valid;
  assign done        = r_done;
  assign fetch_count = r_count;

  // Fetch FSM: PC sequencing, pending-fetch tracking, halt and counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state      <= ST_IDLE;
      r_pc         <= START_ADDR;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_done       <= 1'b0;
      r_count      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pc    <= START_ADDR;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!stall) begin
            // The presented instruction is consumed by decode this cycle.
            if (r_pend_valid) r_count <= sat_inc(r_count);
            if (w_halt) begin
              r_state      <= ST_HALT;
              r_done       <= 1'b1;
              r_pend_valid <= 1'b0;
            end else if (w_jump) begin
              // The sequential fetch issued this cycle is squashed.
              r_pc         <= jump_addr;
              r_pend_valid <= 1'b0;
            end else begin
              r_pend_valid <= 1'b1;
              r_pend_pc    <= r_pc;
              r_pc         <= w_pc_inc;
            end
          end
        end
        ST_HALT: begin
          if (start) begin
            r_done  <= 1'b0;
            r_pc    <= START_ADDR;
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a behavioural ins_mem and a cycle-level
// reference model of the fetch rules; directed scenarios then random traffic.
module tb_fetch_unit;

  logic       clk;
  logic       rstN;
  logic       start, stall, jump;
  logic [7:0] jump_addr;
  logic [8:0] ins_in;
  logic [7:0] PC_address;
  logic       rEn;
  logic [8:0] ins_out;
  logic [7:0] ins_pc;
  logic       ins_valid;
  logic       done;
  logic [15:0] fetch_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] mem [256];

  // Reference model: mode 0 idle, 1 running, 2 halted.
  int m_mode, m_next, m_pc, m_cnt;
  bit m_valid, m_done;

  fetch_unit dut (
    .clk(clk), .rstN(rstN), .start(start), .stall(stall), .jump(jump),
    .jump_addr(jump_addr), .ins_in(ins_in), .PC_address(PC_address), .rEn(rEn),
    .ins_out(ins_out), .ins_pc(ins_pc), .ins_valid(ins_valid), .done(done),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ins_mem: registered read, output held when rEn is low.
  always @(posedge clk) if (rEn) ins_in <= mem[PC_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_next = 0; m_pc = 0; m_cnt = 0; m_valid = 0; m_done = 0;
  endtask

  task automatic model_step(input bit st, input bit sl, input bit jp, input int ja);
    case (m_mode)
      0: if (st) begin m_next = 0; m_mode = 1; end
      2: if (st) begin m_done = 0; m_next = 0; m_mode = 1; end
      default: if (!sl) begin
        if (m_valid && m_cnt < 65535) m_cnt++;
        if (m_valid && mem[m_pc] == 9'h1FF) begin
          m_mode = 2; m_done = 1; m_valid = 0;
        end else if (m_valid && jp) begin
          m_next = ja; m_valid = 0;
        end else begin
          m_valid = 1; m_pc = m_next; m_next = (m_next + 1) % 256;
        end
      end
    endcase
  endtask

  task automatic check_model(input bit sl);
    bit exp_ren;
    exp_ren = (m_mode == 1) && !sl;
    chk("rEn", rEn, exp_ren);
    if (exp_ren) chk("PC_address", PC_address, m_next);
    chk("ins_valid", ins_valid, m_valid);
    if (m_valid) begin
      chk("ins_pc", ins_pc, m_pc);
      chk("ins_out", ins_out, mem[m_pc]);
    end
    chk("done", done, m_done);
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  // One clock cycle: drive at negedge, check, advance the model for the next edge.
  task automatic cycle(input bit st, input bit sl, input bit jp, input int ja);
    @(negedge clk);
    start = st; stall = sl; jump = jp; jump_addr = 8'(ja);
    #1;
    check_model(sl);
    model_step(st, sl, jp, ja);
  endtask

  task automatic run_until_pc(input int pc, input int budget);
    int n = 0;
    while (!(m_valid && m_pc == pc) && n < budget) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    if (n >= budget) chk("timeout_pc", 0, 1);
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (!m_done && n < budget) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    if (n >= budget) chk("timeout_done", 0, 1);
  endtask

  // Reset asserted between edges; effects must be visible before the next edge.
  task automatic async_reset();
    @(negedge clk);
    start = 0; stall = 0; jump = 0; jump_addr = 0;
    #2 rstN = 1'b0;
    #1;
    model_reset();
    chk("rst_ins_valid", ins_valid, 0);
    chk("rst_pc", PC_address, 0);
    chk("rst_done", done, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_rEn", rEn, 0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 9'(i);
    mem[8'h20] = 9'h1FF;
    mem[8'hFF] = 9'd7;
    start = 0; stall = 0; jump = 0; jump_addr = 0;
    rstN = 1'b0;
    model_reset();
    #12;
    chk("reset_valid", ins_valid, 0);
    chk("reset_pc", PC_address, 0);
    chk("reset_ins_pc", ins_pc, 0);
    chk("reset_done", done, 0);
    chk("reset_count", fetch_count, 0);
    @(negedge clk);
    rstN = 1'b1;

    // Start and sequential fetch, then stall while ins_pc=5.
    cycle(0, 0, 0, 0);
    chk("idle_rEn", rEn, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("first_rEn", rEn, 1);
    chk("first_not_valid", ins_valid, 0);
    cycle(0, 0, 0, 0);
    chk("first_valid_pc", ins_pc, 0);
    run_until_pc(5, 20);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 0);
      chk("stall_hold_pc", ins_pc, 5);
      chk("stall_hold_ins", ins_out, 5);
      chk("stall_rEn", rEn, 0);
    end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("after_stall_pc", ins_pc, 6);

    // Jump to 0xFF, then wrap to 0 with no bubble.
    run_until_pc(8, 20);
    cycle(0, 0, 1, 8'hFF);
    cycle(0, 0, 0, 0);
    chk("jump_bubble", ins_valid, 0);
    cycle(0, 0, 0, 0);
    chk("jump_ff_pc", ins_pc, 8'hFF);
    chk("jump_ff_ins", ins_out, 7);
    cycle(0, 0, 0, 0);
    chk("wrap_pc", ins_pc, 0);
    chk("wrap_valid", ins_valid, 1);

    // Jump at ins_pc=3 to 0x10 squashes instruction 4.
    run_until_pc(3, 20);
    cycle(0, 0, 1, 8'h10);
    cycle(0, 0, 0, 0);
    chk("jump10_bubble", ins_valid, 0);
    cycle(0, 0, 0, 0);
    chk("jump10_pc", ins_pc, 8'h10);
    chk("jump10_ins", ins_out, 8'h10);
    run_until_done(100);
    cycle(0, 0, 0, 0);
    chk("halt_done", done, 1);
    chk("halt_rEn", rEn, 0);

    // Mid-stream async reset, then a clean run to halt and a restart.
    async_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 0);
      chk("post_rst_idle", rEn, 0);
    end
    cycle(1, 0, 0, 0);
    run_until_done(100);
    cycle(0, 0, 0, 0);
    chk("halt_count", fetch_count, 16'h21);
    chk("halt_valid", ins_valid, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("restart_done", done, 0);
    cycle(0, 0, 0, 0);
    chk("restart_pc", ins_pc, 0);
    chk("restart_valid", ins_valid, 1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0, int'($urandom_range(0, 255)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
